// File: rtl/axis_stream_scheduler.sv
// Round-robin burst scheduler sharing one AXI4-Stream sink between NUM_SRC
// sources. Each grant passes burst_len words from one source, tagged via tdest.
//
// Ports:
//   aclk, aresetn     clock, asynchronous active-low reset
//   src_enable        per-source eligibility mask
//   burst_len         words per grant, sampled when a grant is made (0 -> 1)
//   s_axis_*          packed per-source streams, source i at [i*W +: W]
//   m_axis_*          muxed output stream, tdest = granted source,
//                     tlast = final word of the burst
//   busy              high while a grant is held
module axis_stream_scheduler #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int NUM_SRC        = 4,
    parameter int SRC_ID_WIDTH   = 2,
    parameter int LEN_WIDTH      = 16
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [NUM_SRC-1:0]                src_enable,
    input  logic [LEN_WIDTH-1:0]              burst_len,
    input  logic [NUM_SRC*AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]                s_axis_tvalid,
    output logic [NUM_SRC-1:0]                s_axis_tready,
    output logic [AXI_DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [SRC_ID_WIDTH-1:0]           m_axis_tdest,
    output logic                              busy
);

    localparam int W = AXI_DATA_WIDTH;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t                  state, state_d;
    logic [SRC_ID_WIDTH-1:0] grant, grant_d;
    logic [SRC_ID_WIDTH-1:0] last_grant, last_grant_d;
    logic [LEN_WIDTH-1:0]    count, count_d;
    logic [LEN_WIDTH-1:0]    len, len_d;

    logic [NUM_SRC-1:0]      cand;
    logic                    found;
    logic [SRC_ID_WIDTH-1:0] pick;
    logic                    xfer;
    logic                    at_last;

    // Search upward from last_grant+1 so the previous winner is tried last.
    always_comb begin
        cand  = src_enable & s_axis_tvalid;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (!found && cand[(int'(last_grant) + k) % NUM_SRC]) begin
                found = 1'b1;
                pick  = SRC_ID_WIDTH'((int'(last_grant) + k) % NUM_SRC);
            end
        end
    end

    // Pass-through of the granted source; everything is low outside a burst.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        m_axis_tdest  = '0;
        m_axis_tlast  = 1'b0;
        busy          = 1'b0;
        if (state == BURST) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant == SRC_ID_WIDTH'(i)) begin
                    m_axis_tdata     = s_axis_tdata[i*W +: W];
                    m_axis_tvalid    = s_axis_tvalid[i];
                    s_axis_tready[i] = m_axis_tready;
                end
            end
            m_axis_tdest = grant;
            m_axis_tlast = at_last & m_axis_tvalid;
            busy         = 1'b1;
        end
    end

    assign at_last = (count == len - LEN_WIDTH'(1));
    assign xfer    = m_axis_tvalid & m_axis_tready;

    always_comb begin
        state_d      = state;
        grant_d      = grant;
        last_grant_d = last_grant;
        count_d      = count;
        len_d        = len;
        case (state)
            IDLE: begin
                if (found) begin
                    state_d = BURST;
                    grant_d = pick;
                    count_d = '0;
                    len_d   = (burst_len == '0) ? LEN_WIDTH'(1) : burst_len;
                end
            end
            BURST: begin
                if (xfer) begin
                    if (at_last) begin
                        state_d      = IDLE;
                        last_grant_d = grant;
                        count_d      = '0;
                    end else begin
                        count_d = count + LEN_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= SRC_ID_WIDTH'(NUM_SRC - 1);
            count      <= '0;
            len        <= '0;
        end else begin
            state      <= state_d;
            grant      <= grant_d;
            last_grant <= last_grant_d;
            count      <= count_d;
            len        <= len_d;
        end
    end

endmodule

// File: tb/tb_axis_stream_scheduler.sv
// Scoreboard bench for axis_stream_scheduler: expected words are queued as
// stimulus is set up and compared as the output stream delivers them.
module tb_axis_stream_scheduler;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [3:0]    src_enable;
    logic [15:0]   burst_len;
    logic [127:0]  s_axis_tdata;
    logic [3:0]    s_axis_tvalid;
    logic [3:0]    s_axis_tready;
    logic [31:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [1:0]    m_axis_tdest;
    logic          busy;

    typedef struct packed {
        logic [1:0]  dest;
        logic        last;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] seq[4];
    logic [23:0] nxt[4];
    int          n_tests = 0;
    int          n_fail  = 0;

    axis_stream_scheduler dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .src_enable    (src_enable),
        .burst_len     (burst_len),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdest  (m_axis_tdest),
        .busy          (busy)
    );

    always #5 aclk = ~aclk;

    // Source i presents {i, running sequence number}.
    always_comb begin
        for (int i = 0; i < 4; i++)
            s_axis_tdata[i*32 +: 32] = {8'(i), seq[i]};
    end

    always @(posedge aclk) begin
        for (int i = 0; i < 4; i++)
            if (s_axis_tvalid[i] && s_axis_tready[i])
                seq[i] <= seq[i] + 24'd1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word",
                    {m_axis_tdest, m_axis_tlast, m_axis_tdata},
                    64'hFFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("word", {m_axis_tdest, m_axis_tlast, m_axis_tdata}, e);
            end
        end
    end

    task automatic push_burst(input int src, input int n, input int len);
        for (int j = 0; j < n; j++) begin
            exp_t e;
            e.dest = 2'(src);
            e.last = (j == len - 1);
            e.data = {8'(src), nxt[src]};
            sb.push_back(e);
            nxt[src] = nxt[src] + 24'd1;
        end
    endtask

    task automatic do_reset();
        aresetn       = 1'b0;
        src_enable    = '0;
        s_axis_tvalid = '0;
        m_axis_tready = 1'b0;
        burst_len     = '0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
    endtask

    task automatic drain(input int max);
        int t;
        t = 0;
        #1;
        while (sb.size() != 0 && t < max) begin
            @(negedge aclk);
            #1;
            t++;
        end
        chk("drained", 64'(sb.size()), 0);
        @(posedge aclk);
        #1;
        s_axis_tvalid = '0;
        m_axis_tready = 1'b0;
    endtask

    task automatic wait_size(input int lim, input int max);
        int t;
        t = 0;
        while (sb.size() > lim && t < max) begin
            @(negedge aclk);
            #1;
            t++;
        end
        chk("wait_size", 64'(sb.size() <= lim), 1);
    endtask

    task automatic check_busy(input string tag, input int n, input int l);
        @(posedge aclk);
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            chk(tag, 64'(busy), 64'((i % (l + 1)) != l));
        end
    endtask

    bit vt[9] = '{1, 1, 1, 0, 0, 1, 1, 1, 0};
    bit rt[9] = '{1, 1, 0, 1, 1, 1, 0, 1, 0};

    initial begin
        for (int i = 0; i < 4; i++) begin
            seq[i] = '0;
            nxt[i] = '0;
        end
        do_reset();
        chk("rst_out", {s_axis_tready, m_axis_tvalid, m_axis_tlast,
                        m_axis_tdest, busy, m_axis_tdata}, 0);

        // Reset mid-burst, then fresh arbitration starts at source 0
        src_enable    = 4'b0100;
        s_axis_tvalid = 4'b0100;
        burst_len     = 16'd8;
        m_axis_tready = 1'b1;
        push_burst(2, 3, 8);
        wait_size(0, 50);
        @(posedge aclk);
        #1;
        chk("t1_busy_pre", 64'(busy), 1);
        aresetn = 1'b0;
        #1;
        chk("t1_async_rst", {s_axis_tready, m_axis_tvalid, m_axis_tlast,
                             m_axis_tdest, busy}, 0);
        src_enable    = 4'b1111;
        s_axis_tvalid = 4'b1111;
        burst_len     = 16'd1;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        for (int s = 0; s < 4; s++) push_burst(s, 1, 1);
        drain(50);

        // Round-robin order with one bubble between bursts
        do_reset();
        src_enable    = 4'b1111;
        s_axis_tvalid = 4'b1111;
        burst_len     = 16'd4;
        m_axis_tready = 1'b1;
        for (int b = 0; b < 5; b++) push_burst(b % 4, 4, 4);
        check_busy("t2_busy", 24, 4);
        drain(50);

        // Backpressure and valid stall on a single source
        do_reset();
        src_enable = 4'b1111;
        burst_len  = 16'd3;
        push_burst(1, 3, 3);
        for (int c = 0; c < 9; c++) begin
            s_axis_tvalid = {2'b00, vt[c], 1'b0};
            m_axis_tready = rt[c];
            @(negedge aclk);
            chk("t3_other_rdy", 64'(s_axis_tready & 4'b1101), 0);
            @(posedge aclk);
            #1;
        end
        drain(5);

        // Enable mask, and disabling the granted source mid-burst
        do_reset();
        src_enable    = 4'b1010;
        s_axis_tvalid = 4'b1111;
        burst_len     = 16'd4;
        m_axis_tready = 1'b1;
        push_burst(1, 4, 4);
        push_burst(3, 4, 4);
        push_burst(1, 4, 4);
        push_burst(3, 4, 4);
        push_burst(1, 4, 4);
        wait_size(7, 100);
        @(posedge aclk);
        #1 src_enable = 4'b0010;
        drain(100);

        // burst_len = 0 behaves as single-word bursts
        do_reset();
        src_enable    = 4'b0001;
        s_axis_tvalid = 4'b0001;
        burst_len     = 16'd0;
        m_axis_tready = 1'b1;
        for (int b = 0; b < 3; b++) push_burst(0, 1, 1);
        drain(30);

        // Maximum length, with burst_len changed mid-burst
        do_reset();
        src_enable    = 4'b0100;
        s_axis_tvalid = 4'b0100;
        burst_len     = 16'hFFFF;
        m_axis_tready = 1'b1;
        push_burst(2, 65535, 65535);
        wait_size(65530, 100);
        @(posedge aclk);
        #1 burst_len = 16'd2;
        drain(70000);
        push_burst(2, 2, 2);
        s_axis_tvalid = 4'b0100;
        m_axis_tready = 1'b1;
        drain(20);

        // Single source re-granted after one idle cycle
        do_reset();
        src_enable    = 4'b1111;
        s_axis_tvalid = 4'b1000;
        burst_len     = 16'd2;
        m_axis_tready = 1'b1;
        for (int b = 0; b < 3; b++) push_burst(3, 2, 2);
        check_busy("t6_busy", 8, 2);
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
